// File: rtl/mul_sequencer_if.sv
// Execute-stage MUL handshake bundle between the pipeline (master) and the
// multi-cycle multiply sequencer (slave).
`timescale 1ns/1ps
interface mul_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             StartE;
    logic             AbortE;
    logic [WIDTH-1:0] SrcAE;
    logic [WIDTH-1:0] SrcBE;
    logic             StallMul;
    logic             MulDone;
    logic [WIDTH-1:0] MulResult;
    logic [1:0]       BusyState;

    // Start is accepted only in IDLE with no abort; MulDone is a one-cycle
    // valid for MulResult, and StallMul holds the pipeline until then.
    modport master (
        output StartE, AbortE, SrcAE, SrcBE,
        input  StallMul, MulDone, MulResult, BusyState
    );

    modport slave (
        input  StartE, AbortE, SrcAE, SrcBE,
        output StallMul, MulDone, MulResult, BusyState
    );
endinterface

// File: rtl/mul_sequencer.sv
// Iterative shift-add multiplier for MUL in Execute: consumes BITS_PER_CYCLE
// multiplier bits per BUSY cycle and stalls the pipeline until DONE.
`timescale 1ns/1ps
module mul_sequencer #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    mul_sequencer_if.slave  bus
);
    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               w_accept;
    logic               w_final;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_result;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   w_acc_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_final      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.StartE && !bus.AbortE) begin
                    w_accept     = 1'b1;
                    w_next_state = S_BUSY;
                end
            end
            S_BUSY: begin
                // Abort takes priority even over the final iteration.
                if (bus.AbortE) begin
                    w_next_state = S_IDLE;
                end else if (r_cnt == CNT_W'(N - 1)) begin
                    w_final      = 1'b1;
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // One iteration: add the shifted multiplicand for each set multiplier bit.
    always_comb begin
        w_acc_next = r_acc;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            if (r_b[k]) begin
                w_acc_next = w_acc_next + (r_a << k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_a   <= bus.SrcAE;
            r_b   <= bus.SrcBE;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (r_state == S_BUSY && !bus.AbortE) begin
            r_acc <= w_acc_next;
            r_a   <= r_a << BITS_PER_CYCLE;
            r_b   <= r_b >> BITS_PER_CYCLE;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_final) begin
                r_result <= w_acc_next;
            end
        end
    end

    assign bus.StallMul  = w_accept || (r_state == S_BUSY);
    assign bus.MulDone   = (r_state == S_DONE);
    assign bus.MulResult = r_result;
    assign bus.BusyState = r_state;
endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer: scoreboarded products, stall lengths,
// back-to-back, abort, mid-operation reset and a BITS_PER_CYCLE sweep.
`timescale 1ns/1ps
module tb_mul_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_q1[$];
    logic [31:0] exp_q8[$];

    mul_sequencer_if #(.WIDTH(32)) m_if ();
    mul_sequencer_if #(.WIDTH(32)) s1_if ();
    mul_sequencer_if #(.WIDTH(32)) s8_if ();

    mul_sequencer #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (m_if)
    );
    mul_sequencer #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (s1_if)
    );
    mul_sequencer #(.WIDTH(32), .BITS_PER_CYCLE(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (s8_if)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Starts a MUL on the main DUT in an IDLE cycle and follows it to MulDone.
    // StartE is left high, as the departing MUL still holds it in DONE.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input string tag);
        int stall_cnt;
        int busy_cnt;
        bit done;
        @(negedge clk);
        m_if.StartE = 1'b1;
        m_if.AbortE = 1'b0;
        m_if.SrcAE  = a;
        m_if.SrcBE  = b;
        exp_q.push_back(a * b);
        #1;
        check({tag, " accept_state"}, 32'(m_if.BusyState), 32'd0);
        check({tag, " accept_nodone"}, 32'(m_if.MulDone), 32'd0);
        stall_cnt = 0;
        busy_cnt  = 0;
        done      = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (c > 0) begin
                @(negedge clk);
                #1;
            end
            if (m_if.StallMul) stall_cnt++;
            if (m_if.BusyState == 2'd1) busy_cnt++;
            if (m_if.MulDone) begin
                done = 1'b1;
                check({tag, " result"}, m_if.MulResult, exp_q.pop_front());
                check({tag, " done_state"}, 32'(m_if.BusyState), 32'd2);
            end
        end
        check({tag, " done_seen"}, 32'(done), 32'd1);
        if (!done) exp_q.delete();
        check({tag, " stall_len"}, 32'(stall_cnt), 32'd9);
        check({tag, " busy_len"}, 32'(busy_cnt), 32'd8);
    endtask

    initial begin
        int pulses;
        int st1, st8;
        bit d1, d8;
        logic [31:0] prev;

        rst_n = 1'b0;
        m_if.StartE = 0; m_if.AbortE = 0; m_if.SrcAE = 0; m_if.SrcBE = 0;
        s1_if.StartE = 0; s1_if.AbortE = 0; s1_if.SrcAE = 0; s1_if.SrcBE = 0;
        s8_if.StartE = 0; s8_if.AbortE = 0; s8_if.SrcAE = 0; s8_if.SrcBE = 0;
        repeat (2) @(negedge clk);
        #1;
        check("reset state", 32'(m_if.BusyState), 32'd0);
        check("reset result", m_if.MulResult, 32'd0);
        check("reset done", 32'(m_if.MulDone), 32'd0);
        check("reset stall", 32'(m_if.StallMul), 32'd0);
        rst_n = 1'b1;

        // Basic product, then return to IDLE.
        run_op(32'd7, 32'd6, "op_7x6");
        @(negedge clk);
        m_if.StartE = 1'b0;
        #1;
        check("post_done state", 32'(m_if.BusyState), 32'd0);
        check("post_done stall", 32'(m_if.StallMul), 32'd0);
        check("post_done done", 32'(m_if.MulDone), 32'd0);

        // Signed-looking operands and result hold between operations.
        run_op(32'hFFFF_FFFD, 32'd5, "op_m3x5");
        @(negedge clk);
        m_if.StartE = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("hold result", m_if.MulResult, 32'hFFFF_FFF1);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, "op_m1xm1");
        @(negedge clk);
        m_if.StartE = 1'b0;

        // Back-to-back: StartE held through DONE, next MUL the following cycle.
        run_op(32'd7, 32'd6, "b2b_first");
        run_op(32'd3, 32'd4, "b2b_second");
        @(negedge clk);
        m_if.StartE = 1'b0;

        // Abort on the 4th BUSY cycle.
        prev = 32'd12;
        @(negedge clk);
        m_if.StartE = 1'b1; m_if.SrcAE = 32'd100; m_if.SrcBE = 32'd200;
        repeat (4) @(negedge clk);
        m_if.AbortE = 1'b1;
        #1;
        check("abort busy_state", 32'(m_if.BusyState), 32'd1);
        @(negedge clk);
        m_if.StartE = 1'b0; m_if.AbortE = 1'b0;
        #1;
        check("abort idle_state", 32'(m_if.BusyState), 32'd0);
        check("abort stall", 32'(m_if.StallMul), 32'd0);
        check("abort result_kept", m_if.MulResult, prev);
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            if (m_if.MulDone) pulses++;
            @(negedge clk);
            #1;
        end
        check("abort no_done", 32'(pulses), 32'd0);

        // Reset during BUSY cycle 5, then a fresh operation.
        @(negedge clk);
        m_if.StartE = 1'b1; m_if.SrcAE = 32'd5; m_if.SrcBE = 32'd5;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        m_if.StartE = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midreset state", 32'(m_if.BusyState), 32'd0);
        check("midreset result", m_if.MulResult, 32'd0);
        check("midreset done", 32'(m_if.MulDone), 32'd0);
        run_op(32'd9, 32'd11, "op_after_reset");
        @(negedge clk);
        m_if.StartE = 1'b0;

        // Abort coinciding with the final iteration: no DONE.
        @(negedge clk);
        m_if.StartE = 1'b1; m_if.SrcAE = 32'd13; m_if.SrcBE = 32'd17;
        repeat (8) @(negedge clk);
        m_if.AbortE = 1'b1;
        #1;
        check("final_abort busy_state", 32'(m_if.BusyState), 32'd1);
        @(negedge clk);
        m_if.StartE = 1'b0; m_if.AbortE = 1'b0;
        #1;
        check("final_abort idle_state", 32'(m_if.BusyState), 32'd0);
        check("final_abort done", 32'(m_if.MulDone), 32'd0);
        check("final_abort result_kept", m_if.MulResult, 32'd99);

        // BITS_PER_CYCLE sweep: 1 and 8.
        @(negedge clk);
        s1_if.StartE = 1'b1; s1_if.SrcAE = 32'h1234_5678; s1_if.SrcBE = 32'h9ABC_DEF0;
        s8_if.StartE = 1'b1; s8_if.SrcAE = 32'h1234_5678; s8_if.SrcBE = 32'h9ABC_DEF0;
        exp_q1.push_back(32'h1234_5678 * 32'h9ABC_DEF0);
        exp_q8.push_back(32'h1234_5678 * 32'h9ABC_DEF0);
        #1;
        st1 = 0; st8 = 0; d1 = 1'b0; d8 = 1'b0;
        for (int c = 0; c < 60 && !(d1 && d8); c++) begin
            if (c > 0) begin
                @(negedge clk);
                #1;
            end
            if (s1_if.StallMul && !d1) st1++;
            if (s8_if.StallMul && !d8) st8++;
            if (s1_if.MulDone && !d1) begin
                d1 = 1'b1;
                check("sweep1 result", s1_if.MulResult, exp_q1.pop_front());
                s1_if.StartE = 1'b0;
            end
            if (s8_if.MulDone && !d8) begin
                d8 = 1'b1;
                check("sweep8 result", s8_if.MulResult, exp_q8.pop_front());
                s8_if.StartE = 1'b0;
            end
        end
        check("sweep1 done_seen", 32'(d1), 32'd1);
        check("sweep8 done_seen", 32'(d8), 32'd1);
        check("sweep1 stall_len", 32'(st1), 32'd33);
        check("sweep8 stall_len", 32'(st8), 32'd5);
        check("sweep ref_product", 32'h1234_5678 * 32'h9ABC_DEF0, 32'h242D_2080);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
